rice_core_if_stage: RTL
=======================

Name: rice_core_if_stage

Overview:
- Instruction fetch stage of the rice core.
- Issues in-order fetch requests on the instruction bus, with up to DEPTH requests outstanding.
- Buffers returning instruction words together with their PCs and presents them to the decode stage as the IF result (valid/pc/inst).
- Handles stall backpressure from downstream and pipeline flush/redirect. Responses to requests issued before a flush are discarded.

Parameters:
- XLEN, 32, width of PC, address and instruction word.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2, fetch entries in flight (outstanding plus buffered); power of two, minimum 2.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- o_request_valid  output  1  fetch request valid.
- i_request_ready  input  1  bus accepts request; ack = o_request_valid && i_request_ready.
- o_request_address  output  XLEN  fetch address, word aligned.
- i_response_valid  input  1  read data returned, in request order.
- i_response_data  input  XLEN  instruction word.
- i_stall  input  1  decode cannot accept this cycle.
- i_flush  input  1  redirect fetch.
- i_flush_pc  input  XLEN  redirect target; bits [1:0] ignored (treated as 0).
- o_if_valid  output  1  IF result valid.
- o_if_pc  output  XLEN  PC of presented instruction.
- o_if_inst  output  XLEN  presented instruction.

Behaviour:
Entry buffer:
- Circular buffer of DEPTH entries {pc, inst, filled}, with allocate, fill and pop pointers of log2(DEPTH) bits that wrap modulo DEPTH.
- count = number of allocated entries, range 0..DEPTH.

Request issue:
- o_request_valid = !i_rst && !i_flush && (count < DEPTH).
- o_request_address = fetch_pc.
- On ack: allocate an entry with pc = fetch_pc and filled = 0, then fetch_pc += 4 (wraps modulo 2^XLEN).
- While o_request_valid is high and the bus has not acked, o_request_address is held constant.

Response:
- The response is always accepted; there is no ready signal.
- If discard_count > 0: drop the word and decrement discard_count.
- Otherwise: write inst into the fill-pointer entry, set filled = 1, advance the fill pointer.

Output:
- o_if_valid = head entry filled && !i_flush.
- o_if_pc and o_if_inst come from the head entry.
- Pop when o_if_valid && !i_stall.
- Combinational path from buffer to output; the response word can be presented the cycle after i_response_valid.
- Minimum latency: ack at cycle N, response at N+k, o_if_valid at N+k+1.

Flush (wins over everything else in the same cycle):
- All entries are freed: count = 0 and pointers reset to 0.
- Any same-cycle pop or fill is ignored.
- discard_count = (number of allocated unfilled entries) minus (1 if a non-discarded response arrives this cycle), plus the existing discard_count minus (1 if a discarded response arrives this cycle).
- fetch_pc <= {i_flush_pc[XLEN-1:2], 2'b00}.
- No request is issued in the flush cycle.
- New requests are issued while discard_count > 0. Issue is allowed only when count + discard_count < DEPTH.

Simultaneous events:
- Ack, fill and pop in the same cycle all apply.
- count' = count + ack - pop.

Reset:
- fetch_pc = RESET_PC.
- count = 0, discard_count = 0, all filled = 0.
- o_request_valid = 0, o_if_valid = 0.
- o_request_address, o_if_pc and o_if_inst are driven from reset state: RESET_PC and 0.
- A mid-operation reset drops all in-flight entries. The bus must not return responses for requests issued before reset.

Optional Feature:
RICE_CORE_IF_STAGE_ASSERTION_EN
- Defined: the following SVA checks are compiled in; each reports $error on violation and is disabled during i_rst.
  - i_response_valid with no unfilled entry and discard_count == 0.
  - o_request_address changes while a request is pending and not acked.
  - count > DEPTH.
  - i_flush_pc[1:0] != 0.
- Undefined: no assertion code is generated. Functional behaviour is identical.

Test Plan:
- Reset release, bus ready = 1, response 1 cycle after ack with data 32'h0000_0013 -> first request address 32'h0; o_if_valid=1 with pc=0 and inst=0x13; subsequent addresses 4, 8, ...
- i_request_ready=0 for 5 cycles -> o_request_valid stays 1 and address stays 32'h4; one ack on release; no duplicate entry.
- i_stall=1 for 4 cycles with DEPTH=2 -> at most 2 acks, then o_request_valid=0; o_if_pc held; after release pcs pop in order 0, 4, 8.
- Two requests outstanding (pcs 8, C), i_flush with i_flush_pc=32'h100 -> next address 0x100; the two old responses are dropped; first o_if_pc after flush is 0x100.
- Flush in the same cycle as a response and a pop -> the response is counted once: discard_count = outstanding - 1; no stale pc is presented.
- i_rst asserted mid-stream with two entries buffered -> next cycle o_if_valid=0 and o_request_valid=0; after release, first address is RESET_PC.

Source files
------------

// File: rtl/rice_core_if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rice_core_if_stage : in-order instruction fetch with DEPTH entries in    |
// | flight. Optional SVA checks: RICE_CORE_IF_STAGE_ASSERTION_EN             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rice_core_if_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
    parameter int               DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_request_valid,
    input  logic            i_request_ready,
    output logic [XLEN-1:0] o_request_address,
    input  logic            i_response_valid,
    input  logic [XLEN-1:0] i_response_data,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_pc,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_pc,
    output logic [XLEN-1:0] o_if_inst
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [XLEN-1:0]    r_fetch_pc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_discard;
    logic [c_PTR_W-1:0] r_alloc_ptr;
    logic [c_PTR_W-1:0] r_fill_ptr;
    logic [c_PTR_W-1:0] r_pop_ptr;
    logic [XLEN-1:0]    r_pc   [DEPTH];
    logic [XLEN-1:0]    r_inst [DEPTH];
    logic [DEPTH-1:0]   r_filled;

    logic [c_CNT_W:0]   w_in_flight;
    logic               w_ack;
    logic               w_pop;
    logic               w_fill;
    logic               w_drop;
    logic [c_CNT_W-1:0] w_filled_cnt;
    logic [c_CNT_W-1:0] w_unfilled;
    logic [c_CNT_W-1:0] w_flush_discard;
    logic [XLEN-1:0]    w_flush_target;

    // Requests still owed a discarded response occupy bus slots too.
    assign w_in_flight       = {1'b0, r_count} + {1'b0, r_discard};
    assign o_request_valid   = !i_rst && !i_flush && (w_in_flight < (c_CNT_W+1)'(DEPTH));
    assign o_request_address = r_fetch_pc;
    assign w_ack             = o_request_valid && i_request_ready;

    assign o_if_valid = r_filled[r_pop_ptr] && !i_flush && !i_rst;
    assign o_if_pc    = r_pc[r_pop_ptr];
    assign o_if_inst  = r_inst[r_pop_ptr];
    assign w_pop      = o_if_valid && !i_stall;

    assign w_drop = i_response_valid && (r_discard != '0);
    assign w_fill = i_response_valid && (r_discard == '0);

    always_comb begin
        w_filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_filled_cnt = w_filled_cnt + c_CNT_W'(r_filled[i]);
        end
    end

    // Free entries always have filled cleared, so the popcount covers allocated ones only.
    assign w_unfilled      = r_count - w_filled_cnt;
    assign w_flush_discard = w_unfilled + r_discard - c_CNT_W'(i_response_valid);
    assign w_flush_target  = i_flush_pc & ~XLEN'(3);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc  <= RESET_PC;
            r_count     <= '0;
            r_discard   <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_pop_ptr   <= '0;
            r_filled    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
            end
        end else if (i_flush) begin
            r_fetch_pc  <= w_flush_target;
            r_count     <= '0;
            r_discard   <= w_flush_discard;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_pop_ptr   <= '0;
            r_filled    <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(w_ack) - c_CNT_W'(w_pop);
            if (w_ack) begin
                r_pc[r_alloc_ptr]     <= r_fetch_pc;
                r_filled[r_alloc_ptr] <= 1'b0;
                r_alloc_ptr           <= r_alloc_ptr + c_PTR_W'(1);
                r_fetch_pc            <= r_fetch_pc + XLEN'(4);
            end
            if (w_pop) begin
                r_filled[r_pop_ptr] <= 1'b0;
                r_pop_ptr           <= r_pop_ptr + c_PTR_W'(1);
            end
            if (w_drop) begin
                r_discard <= r_discard - c_CNT_W'(1);
            end
            if (w_fill) begin
                r_inst[r_fill_ptr]   <= i_response_data;
                r_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + c_PTR_W'(1);
            end
        end
    end

`ifdef RICE_CORE_IF_STAGE_ASSERTION_EN
    a_resp_expected: assert property (@(posedge i_clk) disable iff (i_rst)
        i_response_valid |-> ((w_unfilled != '0) || (r_discard != '0)))
        else $error("response with no outstanding request");

    a_addr_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_request_valid && !i_request_ready) |=> (!o_request_valid || $stable(o_request_address)))
        else $error("request address changed while pending");

    a_count_range: assert property (@(posedge i_clk) disable iff (i_rst)
        r_count <= c_CNT_W'(DEPTH))
        else $error("entry count exceeds DEPTH");

    a_flush_align: assert property (@(posedge i_clk) disable iff (i_rst)
        i_flush |-> (i_flush_pc[1:0] == 2'b00))
        else $error("flush target not word aligned");
`endif

endmodule
`default_nettype wire
